mux_src_arb: RTL

Four-channel input buffer and round-robin arbiter that sits directly upstream of the 4:1 data mux. It captures one 4-bit word per channel with a valid/ready handshake and presents the four held words to the mux data inputs. It drives the mux 2-bit select `y` with a registered round-robin grant. It also exposes a single downstream valid/ready handshake for the muxed word.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_src_arb.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the mux source buffer/arbiter.
package mux_pkg;

    localparam int DW  = 4;
    localparam int NCH = 4;

    typedef enum logic {IDLE, GRANT} state_t;
    typedef logic [1:0] ch_t;

    function automatic logic [NCH-1:0] ch_bit(input ch_t c);
        return {{(NCH-1){1'b0}}, 1'b1} << c;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set mask bit at or after start, wrapping.
module rr_pick
    import mux_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  ch_t            start,
    output logic           any,
    output ch_t            win
);

    ch_t idx;

    // Walk from the far end so the nearest set bit overwrites earlier hits.
    always_comb begin
        any = 1'b0;
        win = start;
        idx = start;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = start + ch_t'(k);
            if (mask[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux_src_arb.sv
// Four-channel word buffer with round-robin grant driving a 4:1 mux select.
module mux_src_arb
    import mux_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] in_valid,
    output logic [NCH-1:0] in_ready,
    input  logic [DW-1:0]  in_data_a,
    input  logic [DW-1:0]  in_data_b,
    input  logic [DW-1:0]  in_data_c,
    input  logic [DW-1:0]  in_data_d,
    output logic [DW-1:0]  a,
    output logic [DW-1:0]  b,
    output logic [DW-1:0]  c,
    output logic [DW-1:0]  d,
    output ch_t            y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     xfer_cnt
);

    state_t         state;
    ch_t            ptr;
    logic [NCH-1:0] full;
    logic [DW-1:0]  hold [NCH];
    logic [DW-1:0]  din  [NCH];
    logic [NCH-1:0] cap;
    logic [NCH-1:0] rel;
    logic           hs;
    logic [NCH-1:0] pick_mask;
    ch_t            pick_start;
    logic           pick_any;
    ch_t            pick_win;

    assign din[0] = in_data_a;
    assign din[1] = in_data_b;
    assign din[2] = in_data_c;
    assign din[3] = in_data_d;

    assign a = hold[0];
    assign b = hold[1];
    assign c = hold[2];
    assign d = hold[3];

    assign in_ready = ~full;
    assign cap      = in_valid & ~full;
    assign hs       = (state == GRANT) && out_ready;
    assign rel      = hs ? ch_bit(y) : '0;

    // Words captured this cycle are excluded: only registered full is used.
    assign pick_mask  = full & ~rel;
    assign pick_start = hs ? ch_t'(y + 2'd1) : ch_t'(ptr + 2'd1);

    rr_pick u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .any   (pick_any),
        .win   (pick_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            y         <= 2'd0;
            out_valid <= 1'b0;
            xfer_cnt  <= 8'd0;
            full      <= '0;
            for (int i = 0; i < NCH; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (cap[i]) hold[i] <= din[i];
            full <= (full | cap) & ~rel;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        y         <= pick_win;
                        out_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        ptr      <= y;
                        xfer_cnt <= xfer_cnt + 8'd1;
                        if (pick_any) begin
                            y <= pick_win;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
